schedule_1st_queue: RTL and testbench
=====================================

# schedule_1st_queue

Parametrised replacement for the single-register first scheduling stage, placed between decode stage 2 and the execute stage. It buffers up to DEPTH decoded instructions in a FIFO and uses a valid/ready handshake on both sides. It keeps the FLUSH/STALL/MEM_WAIT semantics of the pipeline and can optionally hold issue on read-after-write register hazards.

## Interface
- DEPTH, 4, number of queue entries; power of two, at least 2
- CNT_W, $clog2(DEPTH+1), width of QUEUE_COUNT
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, synchronous, active-high
- FLUSH  in  1  discard all queued entries
- STALL  in  1  freeze queue: no push, no pop
- MEM_WAIT  in  1  same effect as STALL
- DECODE_2ND_VALID  in  1  upstream instruction present
- DECODE_2ND_READY  out  1  queue accepts this cycle
- DECODE_2ND_PC / _IMM  in  32 each  instruction fields
- DECODE_2ND_OPCODE / _FUNCT7  in  7 each
- DECODE_2ND_RD / _RS1 / _RS2  in  5 each
- DECODE_2ND_FUNCT3  in  3
- SCHEDULE_1ST_VALID  out  1  head entry issuable
- SCHEDULE_1ST_READY  in  1  execute stage accepts
- SCHEDULE_1ST_PC, _OPCODE, _RD, _FUNCT3, _FUNCT7, _IMM  out  same widths as inputs  head fields
- WB_VALID  in  1  register writeback this cycle
- WB_RD  in  5  writeback destination
- QUEUE_COUNT  out  CNT_W  occupied entries

## Operation
- Storage: DEPTH entries holding {PC, OPCODE, RD, FUNCT3, FUNCT7, IMM, RS1, RS2}. Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. A separate count runs 0..DEPTH.
- Ready: DECODE_2ND_READY = !RST && !FLUSH && !STALL && !MEM_WAIT && count < DEPTH. When full, no push is accepted even if a pop happens in the same cycle.
- Push: DECODE_2ND_VALID && DECODE_2ND_READY. The entry is written at the write pointer and the write pointer increments.
- Head issuable: count != 0 && !hold. hold is always 0 unless hazard checking is compiled in.
- Valid gating: SCHEDULE_1ST_VALID = head issuable && !STALL && !MEM_WAIT.
- Pop: SCHEDULE_1ST_VALID && SCHEDULE_1ST_READY. The read pointer increments.
- Count update: push without pop gives count+1; pop without push gives count-1; push and pop together leave count unchanged.
- Output fields: equal to the head entry when SCHEDULE_1ST_VALID = 1, otherwise all zero (a NOP, same as the flushed value).
- Priority: RST, then FLUSH, then STALL/MEM_WAIT, then push/pop.
- FLUSH: pointers and count are cleared at the next edge. Push and pop are both inhibited in the FLUSH cycle.
- RST: clears pointers and count. It also clears the scoreboard when hazard checking is compiled in.
- Entry contents are not cleared on RST or FLUSH; they are masked by the valid gating above.

## Timing
- Reset values: SCHEDULE_1ST_VALID=0, all SCHEDULE_1ST_* fields=0, QUEUE_COUNT=0, DECODE_2ND_READY=0 while RST is high. DECODE_2ND_READY is 1 in the first cycle after RST falls.
- Latency: an instruction pushed at edge k into an empty queue is presented in cycle k+1. This matches the previous single-register stage.
- Throughput: one push and one pop per cycle.
- STALL/MEM_WAIT: SCHEDULE_1ST_VALID drops combinationally in the same cycle. The head is presented again unchanged once both are low.
- FLUSH with STALL asserted: the flush still takes effect at that edge.
- RST asserted mid-stream: all queued entries are lost at that edge.

## Configuration
- Macro: SCHEDULE_1ST_HAZARD_EN.
- Defined:
  - A 31-bit busy scoreboard covers x1..x31; x0 is never busy.
  - On pop, busy[RD] is set when RD != 0 and OPCODE is not 0100011 (store), 1100011 (branch) or 0000000.
  - WB_VALID clears busy[WB_RD]. If the same register is set and cleared in the same cycle, set wins.
  - hold = busy[head RS1] || busy[head RS2].
  - A writeback at edge k releases the held head in cycle k+1. There is no same-cycle bypass.
  - A dependent head behind an issuing producer at edge k is held from cycle k+1.
  - FLUSH clears the whole scoreboard.
- Undefined: hold is tied to 0, no scoreboard is built, and RS1, RS2, WB_VALID and WB_RD are ignored. The ports remain in both builds.

## Test plan
- Fill/drain: DEPTH=4, SCHEDULE_1ST_READY=0, push 5 → READY drops after 4, QUEUE_COUNT=4. Then READY=1 for 4 cycles → PCs pop in order 0x00,0x04,0x08,0x0C, then VALID=0 and fields=0.
- Streaming: VALID and READY held high for 20 cycles → one issue per cycle after 1-cycle latency, QUEUE_COUNT stays at 1, pointers wrap correctly.
- STALL/MEM_WAIT: with 2 entries queued, assert MEM_WAIT for 3 cycles → VALID=0, no push, count stays 2. After release the same head PC is presented.
- FLUSH: with 3 queued plus FLUSH and VALID both high in the same cycle → next cycle count=0, output fields 0, the concurrent push is not taken.
- Hazard (macro defined): issue `addi x5` then queue `add x6,x5,x1` → second is held. WB_VALID=1, WB_RD=5 at edge k → issued in cycle k+1. Same bench with macro undefined → issued back-to-back.
- Reset mid-stream: RST with 2 queued → all outputs 0, READY=0 during RST, READY=1 in the first cycle after RST falls.

Source files
------------

// File: rtl/schedule_1st_queue.sv
// schedule_1st_queue: DEPTH-entry instruction FIFO between decode stage 2 and
// execute, with valid/ready on both sides and FLUSH/STALL/MEM_WAIT control.
// Optional read-after-write hold on the head entry: SCHEDULE_1ST_HAZARD_EN.
//
// Handshake: a transfer happens on a rising CLK edge where VALID and READY
// are both 1 in the preceding cycle; VALID never depends on READY of the same
// side, and a presented head stays unchanged until it is taken.
module schedule_1st_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             STALL,
    input  logic             MEM_WAIT,
    input  logic             DECODE_2ND_VALID,
    output logic             DECODE_2ND_READY,
    input  logic [31:0]      DECODE_2ND_PC,
    input  logic [31:0]      DECODE_2ND_IMM,
    input  logic [6:0]       DECODE_2ND_OPCODE,
    input  logic [6:0]       DECODE_2ND_FUNCT7,
    input  logic [4:0]       DECODE_2ND_RD,
    input  logic [4:0]       DECODE_2ND_RS1,
    input  logic [4:0]       DECODE_2ND_RS2,
    input  logic [2:0]       DECODE_2ND_FUNCT3,
    output logic             SCHEDULE_1ST_VALID,
    input  logic             SCHEDULE_1ST_READY,
    output logic [31:0]      SCHEDULE_1ST_PC,
    output logic [6:0]       SCHEDULE_1ST_OPCODE,
    output logic [4:0]       SCHEDULE_1ST_RD,
    output logic [2:0]       SCHEDULE_1ST_FUNCT3,
    output logic [6:0]       SCHEDULE_1ST_FUNCT7,
    output logic [31:0]      SCHEDULE_1ST_IMM,
    input  logic             WB_VALID,
    input  logic [4:0]       WB_RD,
    output logic [CNT_W-1:0] QUEUE_COUNT
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
`ifdef SCHEDULE_1ST_HAZARD_EN
        logic [4:0]  rs1;
        logic [4:0]  rs2;
`endif
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             entry_in;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stalled;
    logic               push;
    logic               pop;
    logic               hold;

    assign entry_in.pc     = DECODE_2ND_PC;
    assign entry_in.opcode = DECODE_2ND_OPCODE;
    assign entry_in.rd     = DECODE_2ND_RD;
    assign entry_in.funct3 = DECODE_2ND_FUNCT3;
    assign entry_in.funct7 = DECODE_2ND_FUNCT7;
    assign entry_in.imm    = DECODE_2ND_IMM;
`ifdef SCHEDULE_1ST_HAZARD_EN
    assign entry_in.rs1    = DECODE_2ND_RS1;
    assign entry_in.rs2    = DECODE_2ND_RS2;
`endif

    assign stalled = STALL || MEM_WAIT;
    assign head    = mem_q[rd_ptr_q];

    // Full blocks push even if a pop happens in the same cycle.
    assign DECODE_2ND_READY = !RST && !FLUSH && !stalled && (cnt_q < CNT_W'(DEPTH));
    assign push             = DECODE_2ND_VALID && DECODE_2ND_READY;

    // RST and FLUSH also mask VALID so the downstream never sees a transfer
    // that the queue itself discards.
    assign SCHEDULE_1ST_VALID = (cnt_q != '0) && !hold && !stalled && !RST && !FLUSH;
    assign pop                = SCHEDULE_1ST_VALID && SCHEDULE_1ST_READY;

    // A non-presented head reads as an all-zero NOP.
    assign SCHEDULE_1ST_PC     = SCHEDULE_1ST_VALID ? head.pc     : '0;
    assign SCHEDULE_1ST_OPCODE = SCHEDULE_1ST_VALID ? head.opcode : '0;
    assign SCHEDULE_1ST_RD     = SCHEDULE_1ST_VALID ? head.rd     : '0;
    assign SCHEDULE_1ST_FUNCT3 = SCHEDULE_1ST_VALID ? head.funct3 : '0;
    assign SCHEDULE_1ST_FUNCT7 = SCHEDULE_1ST_VALID ? head.funct7 : '0;
    assign SCHEDULE_1ST_IMM    = SCHEDULE_1ST_VALID ? head.imm    : '0;
    assign QUEUE_COUNT         = cnt_q;

    // Next pointers and occupancy from the accepted push/pop of this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/count registers; RST beats FLUSH, both empty the queue.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are left as-is on RST/FLUSH and masked by VALID.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= entry_in;
    end

`ifdef SCHEDULE_1ST_HAZARD_EN
    logic [31:1] busy_q, busy_d;
    logic [31:0] busy_rd;
    logic [31:0] busy_full;
    logic        head_writes_rd;
    logic        busy_unused_x0;

    // Stores, branches and the all-zero opcode never produce a register result.
    assign head_writes_rd = (head.rd != 5'd0)
                          && (head.opcode != 7'b0100011)
                          && (head.opcode != 7'b1100011)
                          && (head.opcode != 7'b0000000);

    assign busy_rd        = {busy_q, 1'b0};
    assign hold           = busy_rd[head.rs1] || busy_rd[head.rs2];
    assign busy_unused_x0 = busy_full[0];

    // Writeback clears first so an issue to the same register wins.
    always_comb begin
        busy_full = {busy_q, 1'b0};
        if (WB_VALID)              busy_full[WB_RD]   = 1'b0;
        if (pop && head_writes_rd) busy_full[head.rd] = 1'b1;
        busy_d = busy_full[31:1];
    end

    // Busy scoreboard register, wiped by RST and FLUSH.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) busy_q <= '0;
        else              busy_q <= busy_d;
    end
`else
    logic unused_hazard_ports;

    assign hold                = 1'b0;
    assign unused_hazard_ports = ^{WB_VALID, WB_RD, DECODE_2ND_RS1, DECODE_2ND_RS2};
`endif

endmodule

// File: tb/tb_schedule_1st_queue.sv
// Directed bench for schedule_1st_queue: accepted pushes feed an expected
// queue, a negedge monitor pops and compares every issued head, and the main
// sequence checks READY/VALID/QUEUE_COUNT at the boundaries.
module tb_schedule_1st_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EW    = 86;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             FLUSH = 1'b0;
    logic             STALL = 1'b0;
    logic             MEM_WAIT = 1'b0;
    logic             dec_valid = 1'b0;
    logic             dec_ready;
    logic [31:0]      dec_pc = '0;
    logic [31:0]      dec_imm = '0;
    logic [6:0]       dec_op = '0;
    logic [6:0]       dec_f7 = '0;
    logic [4:0]       dec_rd = '0;
    logic [4:0]       dec_rs1 = '0;
    logic [4:0]       dec_rs2 = '0;
    logic [2:0]       dec_f3 = '0;
    logic             s_valid;
    logic             s_ready = 1'b0;
    logic [31:0]      s_pc;
    logic [6:0]       s_op;
    logic [4:0]       s_rd;
    logic [2:0]       s_f3;
    logic [6:0]       s_f7;
    logic [31:0]      s_imm;
    logic             wb_valid = 1'b0;
    logic [4:0]       wb_rd = '0;
    logic [CNT_W-1:0] q_count;

    logic [EW-1:0]    exp_q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    schedule_1st_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL), .MEM_WAIT(MEM_WAIT),
        .DECODE_2ND_VALID(dec_valid), .DECODE_2ND_READY(dec_ready),
        .DECODE_2ND_PC(dec_pc), .DECODE_2ND_IMM(dec_imm),
        .DECODE_2ND_OPCODE(dec_op), .DECODE_2ND_FUNCT7(dec_f7),
        .DECODE_2ND_RD(dec_rd), .DECODE_2ND_RS1(dec_rs1), .DECODE_2ND_RS2(dec_rs2),
        .DECODE_2ND_FUNCT3(dec_f3),
        .SCHEDULE_1ST_VALID(s_valid), .SCHEDULE_1ST_READY(s_ready),
        .SCHEDULE_1ST_PC(s_pc), .SCHEDULE_1ST_OPCODE(s_op), .SCHEDULE_1ST_RD(s_rd),
        .SCHEDULE_1ST_FUNCT3(s_f3), .SCHEDULE_1ST_FUNCT7(s_f7), .SCHEDULE_1ST_IMM(s_imm),
        .WB_VALID(wb_valid), .WB_RD(wb_rd), .QUEUE_COUNT(q_count)
    );

    // Clock: 10 time-unit period.
    always #5 CLK = ~CLK;

    function automatic logic [EW-1:0] pack_e(input logic [31:0] pc, input logic [6:0] op,
                                             input logic [4:0] rd, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] imm);
        return {pc, op, rd, f3, f7, imm};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Field values derive from the PC so each entry is distinct.
    task automatic set_instr(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        dec_pc  = pc;
        dec_op  = op;
        dec_rd  = rd;
        dec_rs1 = rs1;
        dec_rs2 = rs2;
        dec_f3  = pc[4:2];
        dec_f7  = pc[8:2];
        dec_imm = ~pc;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
        set_instr(pc, op, rd, rs1, rs2);
        dec_valid = 1'b1;
        tick();
        dec_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare each issued head, record each accepted push.
    initial begin
        forever begin
            @(negedge CLK);
            if (s_valid && s_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_unexpected: got pc %0h, expected no issue", s_pc);
                end else begin
                    check("pop_entry", pack_e(s_pc, s_op, s_rd, s_f3, s_f7, s_imm), exp_q.pop_front());
                end
            end
            if (dec_valid && dec_ready)
                exp_q.push_back(pack_e(dec_pc, dec_op, dec_rd, dec_f3, dec_f7, dec_imm));
            if (RST || FLUSH)
                exp_q.delete();
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        tick();
        @(negedge CLK);
        check("rst_ready", EW'(dec_ready), EW'(0));
        check("rst_valid", EW'(s_valid), EW'(0));
        check("rst_count", EW'(q_count), EW'(0));
        check("rst_fields", pack_e(s_pc, s_op, s_rd, s_f3, s_f7, s_imm), '0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_release_ready", EW'(dec_ready), EW'(1));

        // Fill/drain: five offered, four taken, drained in order.
        tick();
        s_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_instr(32'(i * 4), 7'b0010011, 5'(i + 1), 5'd0, 5'd0);
            dec_valid = 1'b1;
            @(negedge CLK);
            check("fill_ready", EW'(dec_ready), EW'(i < 4));
            tick();
        end
        dec_valid = 1'b0;
        s_ready   = 1'b1;
        @(negedge CLK);
        check("full_count", EW'(q_count), EW'(4));
        check("full_ready", EW'(dec_ready), EW'(0));
        check("full_head_pc", EW'(s_pc), EW'(32'h0));
        for (int i = 0; i < 4; i++) tick();
        @(negedge CLK);
        check("drain_valid", EW'(s_valid), EW'(0));
        check("drain_fields", pack_e(s_pc, s_op, s_rd, s_f3, s_f7, s_imm), '0);
        check("drain_count", EW'(q_count), EW'(0));

        // Streaming: one push and one pop per cycle across pointer wrap.
        tick();
        for (int i = 0; i < 20; i++) begin
            set_instr(32'h100 + 32'(i * 4), 7'b0110011, 5'(i), 5'd0, 5'd0);
            dec_valid = 1'b1;
            @(negedge CLK);
            check("stream_count", EW'(q_count), EW'(i == 0 ? 0 : 1));
            check("stream_valid", EW'(s_valid), EW'(i == 0 ? 0 : 1));
            tick();
        end
        dec_valid = 1'b0;
        tick();
        @(negedge CLK);
        check("stream_end_count", EW'(q_count), EW'(0));

        // MEM_WAIT for three cycles, then STALL for one, with a push offered.
        tick();
        s_ready = 1'b0;
        push_one(32'h200, 7'b0010011, 5'd3, 5'd0, 5'd0);
        push_one(32'h204, 7'b0010011, 5'd4, 5'd0, 5'd0);
        s_ready = 1'b1;
        set_instr(32'h300, 7'b0010011, 5'd7, 5'd0, 5'd0);
        dec_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            MEM_WAIT = (i < 3);
            STALL    = (i == 3);
            @(negedge CLK);
            check("wait_valid", EW'(s_valid), EW'(0));
            check("wait_ready", EW'(dec_ready), EW'(0));
            check("wait_count", EW'(q_count), EW'(2));
            tick();
        end
        MEM_WAIT  = 1'b0;
        STALL     = 1'b0;
        dec_valid = 1'b0;
        @(negedge CLK);
        check("wait_release_valid", EW'(s_valid), EW'(1));
        check("wait_release_pc", EW'(s_pc), EW'(32'h200));
        tick();
        tick();
        @(negedge CLK);
        check("wait_drain_count", EW'(q_count), EW'(0));

        // FLUSH with a concurrent push offered.
        tick();
        s_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(32'h400 + 32'(i * 4), 7'b0010011, 5'd9, 5'd0, 5'd0);
        set_instr(32'h500, 7'b0010011, 5'd9, 5'd0, 5'd0);
        dec_valid = 1'b1;
        FLUSH     = 1'b1;
        tick();
        FLUSH     = 1'b0;
        dec_valid = 1'b0;
        s_ready   = 1'b1;
        @(negedge CLK);
        check("flush_count", EW'(q_count), EW'(0));
        check("flush_valid", EW'(s_valid), EW'(0));
        check("flush_fields", pack_e(s_pc, s_op, s_rd, s_f3, s_f7, s_imm), '0);

        // FLUSH still empties the queue while STALL is high.
        tick();
        s_ready = 1'b0;
        push_one(32'h600, 7'b0010011, 5'd9, 5'd0, 5'd0);
        push_one(32'h604, 7'b0010011, 5'd9, 5'd0, 5'd0);
        STALL = 1'b1;
        FLUSH = 1'b1;
        tick();
        STALL = 1'b0;
        FLUSH = 1'b0;
        @(negedge CLK);
        check("flush_stall_count", EW'(q_count), EW'(0));

        // Queue is usable after the flush; PC 0x700 is issued next.
        tick();
        s_ready = 1'b1;
        push_one(32'h700, 7'b0010011, 5'd0, 5'd0, 5'd0);
        @(negedge CLK);
        check("post_flush_pc", EW'(s_pc), EW'(32'h700));

        // RAW: addi x5 then add x6,x5,x1.
        tick();
        s_ready = 1'b0;
        push_one(32'h800, 7'b0010011, 5'd5, 5'd0, 5'd0);
        push_one(32'h804, 7'b0110011, 5'd6, 5'd5, 5'd1);
        s_ready = 1'b1;
        @(negedge CLK);
        check("haz_producer_pc", EW'(s_pc), EW'(32'h800));
        tick();
        @(negedge CLK);
`ifdef SCHEDULE_1ST_HAZARD_EN
        check("haz_hold_valid", EW'(s_valid), EW'(0));
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        tick();
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        @(negedge CLK);
        check("haz_release_valid", EW'(s_valid), EW'(1));
        check("haz_release_pc", EW'(s_pc), EW'(32'h804));
`else
        check("haz_b2b_valid", EW'(s_valid), EW'(1));
        check("haz_b2b_pc", EW'(s_pc), EW'(32'h804));
`endif
        tick();
        @(negedge CLK);
        check("haz_drain_count", EW'(q_count), EW'(0));

        // Reset mid-stream with two entries queued.
        tick();
        s_ready = 1'b0;
        push_one(32'h900, 7'b0010011, 5'd2, 5'd0, 5'd0);
        push_one(32'h904, 7'b0010011, 5'd2, 5'd0, 5'd0);
        s_ready = 1'b1;
        RST     = 1'b1;
        @(negedge CLK);
        check("midrst_ready", EW'(dec_ready), EW'(0));
        check("midrst_valid", EW'(s_valid), EW'(0));
        check("midrst_fields", pack_e(s_pc, s_op, s_rd, s_f3, s_f7, s_imm), '0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_release_ready", EW'(dec_ready), EW'(1));
        check("midrst_count", EW'(q_count), EW'(0));
        check("midrst_valid_after", EW'(s_valid), EW'(0));

        tick();
        check("scoreboard_empty", EW'(exp_q.size()), EW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
